// File: rtl/readback_arbiter_if.sv
// Readback arbiter bus bundle.
// Groups the producer-side write port (in_data/in_wr/in_busy), the consumer
// valid/ready output (out_data/out_addr/out_urgent/out_valid/out_rdy) and the
// sticky overflow flags (ovf/ovf_clr).
//   master : producers + consumer (drives writes, out_rdy, ovf_clr)
//   slave  : the arbiter itself
interface readback_arbiter_if #(
  parameter int CHS    = 6,
  parameter int DW     = 28,
  parameter int ADDR_W = 4
);
  logic [CHS*DW-1:0] in_data;
  logic [CHS-1:0]    in_wr;
  logic [CHS-1:0]    in_busy;
  logic [DW-1:0]     out_data;
  logic [ADDR_W-1:0] out_addr;
  logic              out_urgent;
  logic              out_valid;
  logic              out_rdy;
  logic [CHS-1:0]    ovf;
  logic [CHS-1:0]    ovf_clr;

  modport master (
    output in_data, in_wr, out_rdy, ovf_clr,
    input  in_busy, out_data, out_addr, out_urgent, out_valid, ovf
  );

  modport slave (
    input  in_data, in_wr, out_rdy, ovf_clr,
    output in_busy, out_data, out_addr, out_urgent, out_valid, ovf
  );
endinterface

// File: rtl/readback_arbiter.sv
// Buffered readback arbiter (core -> Jetson path).
// Each producer channel feeds its own small FIFO; a single registered
// valid/ready output is loaded from the winning channel, tagged with its index.
// Urgent channels (URGENT_MASK) pre-empt normal ones; within a class the pick
// is round-robin (RR=1) or lowest-index (RR=0). Dropped writes set sticky ovf.
// Ports:
//   clk    : system clock
//   rst_n  : asynchronous reset, active low
//   bus    : readback_arbiter_if.slave (writes, busy, output handshake, ovf)
module readback_arbiter #(
  parameter int             CHS         = 6,
  parameter int             DW          = 28,
  parameter int             DEPTH       = 2,
  parameter int             ADDR_W      = 4,
  parameter int             RR          = 1,
  parameter logic [CHS-1:0] URGENT_MASK = '0
) (
  input logic               clk,
  input logic               rst_n,
  readback_arbiter_if.slave bus
);
  localparam int AW   = $clog2(DEPTH);
  localparam int CNTW = AW + 1;
  localparam int CW   = (CHS > 1) ? $clog2(CHS) : 1;
  localparam logic [CNTW-1:0] FULL_CNT = CNTW'(DEPTH);
  localparam logic [CW-1:0]   LAST_CH  = CW'(CHS - 1);

  logic [DW-1:0]   mem_r    [CHS][DEPTH];
  logic [AW-1:0]   wr_ptr_r [CHS];
  logic [AW-1:0]   rd_ptr_r [CHS];
  logic [CNTW-1:0] count_r  [CHS];

  logic [CHS-1:0] full_s, nonempty_s, push_s, drop_s, pop_s;
  logic [CHS-1:0] urg_cand_s, cand_s, ovf_r;
  logic [CW-1:0]  rr_ptr_r, scan_base_s, win_s, idx_s;
  logic [CW:0]    sum_s;
  logic           load_s, grant_s;

  logic [DW-1:0]     out_data_r;
  logic [ADDR_W-1:0] out_addr_r;
  logic              out_urgent_r, out_valid_r;

  // Per-channel status: full/empty from registered counts, push/drop qualification.
  always_comb begin
    full_s     = '0;
    nonempty_s = '0;
    push_s     = '0;
    drop_s     = '0;
    for (int i = 0; i < CHS; i++) begin
      full_s[i]     = (count_r[i] == FULL_CNT);
      nonempty_s[i] = (count_r[i] != '0);
      // A full FIFO drops the write even if it pops this cycle.
      push_s[i]     = bus.in_wr[i] & ~full_s[i];
      drop_s[i]     = bus.in_wr[i] & full_s[i];
    end
  end

  // Candidate selection: urgent class masks out normal channels when present.
  always_comb begin
    urg_cand_s  = nonempty_s & URGENT_MASK;
    cand_s      = (|urg_cand_s) ? urg_cand_s : nonempty_s;
    // Fixed priority is round-robin with the pointer pinned at the last channel.
    scan_base_s = (RR != 0) ? rr_ptr_r : LAST_CH;
    win_s       = '0;
    sum_s       = '0;
    idx_s       = '0;
    // Scan downwards so the candidate nearest after the pointer is assigned last.
    for (int k = CHS; k >= 1; k--) begin
      sum_s = {1'b0, scan_base_s} + (CW+1)'(k);
      sum_s = (sum_s >= (CW+1)'(CHS)) ? (sum_s - (CW+1)'(CHS)) : sum_s;
      idx_s = sum_s[CW-1:0];
      win_s = cand_s[idx_s] ? idx_s : win_s;
    end
    load_s  = ~out_valid_r | bus.out_rdy;
    grant_s = load_s & (|cand_s);
  end

  // Head pop for the winning channel, on the same edge the output loads.
  always_comb begin
    pop_s = '0;
    for (int i = 0; i < CHS; i++) begin
      pop_s[i] = grant_s & (win_s == CW'(i));
    end
  end

  // FIFO pointers and occupancy counts.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < CHS; i++) begin
        wr_ptr_r[i] <= '0;
        rd_ptr_r[i] <= '0;
        count_r[i]  <= '0;
      end
    end else begin
      for (int i = 0; i < CHS; i++) begin
        if (push_s[i]) begin
          wr_ptr_r[i] <= wr_ptr_r[i] + AW'(1);
        end
        if (pop_s[i]) begin
          rd_ptr_r[i] <= rd_ptr_r[i] + AW'(1);
        end
        count_r[i] <= count_r[i] + CNTW'(push_s[i]) - CNTW'(pop_s[i]);
      end
    end
  end

  // FIFO storage; contents are qualified by the counts, so no reset needed.
  always_ff @(posedge clk) begin
    for (int i = 0; i < CHS; i++) begin
      if (push_s[i]) begin
        mem_r[i][wr_ptr_r[i]] <= bus.in_data[i*DW +: DW];
      end
    end
  end

  // Output register, round-robin pointer and sticky overflow flags.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid_r  <= 1'b0;
      out_data_r   <= '0;
      out_addr_r   <= '0;
      out_urgent_r <= 1'b0;
      rr_ptr_r     <= LAST_CH;
      ovf_r        <= '0;
    end else begin
      // A new drop wins over a simultaneous clear.
      ovf_r <= (ovf_r & ~bus.ovf_clr) | drop_s;
      if (load_s) begin
        if (grant_s) begin
          out_valid_r  <= 1'b1;
          out_data_r   <= mem_r[win_s][rd_ptr_r[win_s]];
          out_addr_r   <= ADDR_W'(win_s);
          out_urgent_r <= URGENT_MASK[win_s];
          rr_ptr_r     <= win_s;
        end else begin
          out_valid_r <= 1'b0;
        end
      end
    end
  end

  assign bus.in_busy    = full_s;
  assign bus.out_data   = out_data_r;
  assign bus.out_addr   = out_addr_r;
  assign bus.out_urgent = out_urgent_r;
  assign bus.out_valid  = out_valid_r;
  assign bus.ovf        = ovf_r;
endmodule
